pc_sequencer: RTL and testbench

//  Program-counter register and next-PC sequencer for the single-cycle/multicycle MIPS datapath.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_target_calc.sv | 22 ++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the PC sequencer: FSM states, redirect-select codes and the sequential step.
package pc_pkg;

   typedef enum logic [1:0] {
      ST_RESET_HOLD,
      ST_RUN,
      ST_STALL,
      ST_HALT
   } pc_state_t;

   typedef enum logic [1:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_JMP,
      SEL_JR
   } redir_sel_t;

   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential, PC-relative branch and pseudo-direct jump.
module pc_target_calc
   import pc_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [15:0] branch_imm,
   input  logic [25:0] jump_addr,
   output logic [31:0] seq_target,
   output logic [31:0] br_target,
   output logic [31:0] jmp_target
);

   logic [31:0] br_off;

   always_comb begin
      seq_target = pc + PC_STEP;
      br_off     = {{14{branch_imm[15]}}, branch_imm, 2'b00};
      br_target  = seq_target + br_off;
      jmp_target = {seq_target[31:28], jump_addr, 2'b00};
   end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, fetch FSM and buffered-redirect handling for the MIPS fetch stage.
// Optional MISALIGN_TRAP_EN: halt with misaligned=1 when an applied JR target is not word aligned.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        imem_ready,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic [25:0] jump_addr,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        halt_req,
   output logic        imem_req,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        halted,
   output logic        misaligned
);

   pc_state_t   state;
   redir_sel_t  sel;
   logic [31:0] seq_target, br_target, jmp_target, jr_eff;
   logic [31:0] redir_target, next_pc;
   logic [31:0] pend_target;
   logic        pend_valid;
   logic        redirect, advance, trap;

   pc_target_calc u_calc (
      .pc         (pc),
      .branch_imm (branch_imm),
      .jump_addr  (jump_addr),
      .seq_target (seq_target),
      .br_target  (br_target),
      .jmp_target (jmp_target)
   );

   assign pc_plus4 = seq_target;

   always_comb begin
`ifdef MISALIGN_TRAP_EN
      jr_eff = jr_target;
`else
      jr_eff = jr_target & ~32'h3;
`endif
      sel = SEL_SEQ;
      if (jr)                sel = SEL_JR;
      else if (jump)         sel = SEL_JMP;
      else if (branch_taken) sel = SEL_BR;
      redirect = jr | jump | branch_taken;
      case (sel)
         SEL_JR:  redir_target = jr_eff;
         SEL_JMP: redir_target = jmp_target;
         SEL_BR:  redir_target = br_target;
         default: redir_target = seq_target;
      endcase
      advance = (state == ST_RUN) && imem_ready && !stall;
      // A live redirect beats a buffered one; the buffer beats sequential flow.
      if (redirect)        next_pc = redir_target;
      else if (pend_valid) next_pc = pend_target;
      else                 next_pc = seq_target;
`ifdef MISALIGN_TRAP_EN
      trap = advance && (next_pc[1:0] != 2'b00);
`else
      trap = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_VECTOR;
         state       <= ST_RESET_HOLD;
         imem_req    <= 1'b0;
         halted      <= 1'b0;
         misaligned  <= 1'b0;
         pend_valid  <= 1'b0;
         pend_target <= '0;
      end else begin
         case (state)
            ST_RESET_HOLD: begin
               state    <= ST_RUN;
               imem_req <= 1'b1;
            end
            ST_RUN, ST_STALL: begin
               if (halt_req || trap) begin
                  state      <= ST_HALT;
                  imem_req   <= 1'b0;
                  halted     <= 1'b1;
                  misaligned <= trap && !halt_req;
                  pend_valid <= 1'b0;
               end else begin
                  if (advance) begin
                     pc         <= next_pc;
                     pend_valid <= 1'b0;
                  end else if (redirect) begin
                     pend_valid  <= 1'b1;
                     pend_target <= redir_target;
                  end
                  state <= stall ? ST_STALL : ST_RUN;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed literal checks plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, imem_ready = 1'b1;
   logic        branch_taken = 1'b0, jump = 1'b0, jr = 1'b0, halt_req = 1'b0;
   logic [15:0] branch_imm = '0;
   logic [25:0] jump_addr = '0;
   logic [31:0] jr_target = '0;
   logic        imem_req, halted, misaligned;
   logic [31:0] pc, pc_plus4;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_VECTOR(RV)) dut (
      .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
      .branch_taken(branch_taken), .branch_imm(branch_imm),
      .jump(jump), .jump_addr(jump_addr), .jr(jr), .jr_target(jr_target),
      .halt_req(halt_req), .imem_req(imem_req), .pc(pc), .pc_plus4(pc_plus4),
      .halted(halted), .misaligned(misaligned)
   );

   // Behavioural model: phase 0 = post-reset hold, 1 = fetching, 2 = halted.
   int          m_phase;
   bit          m_stalled;
   bit          m_pend_v;
   bit          m_mis;
   logic [31:0] m_pc, m_pend;

   always @(posedge clk) begin
      logic [31:0] tgt, applied;
      bit          redir, adv;
      if (rst) begin
         m_phase = 0; m_pc = RV; m_stalled = 0; m_pend_v = 0; m_mis = 0; m_pend = '0;
      end else if (m_phase == 0) begin
         m_phase = 1; m_stalled = 0;
      end else if (m_phase == 1) begin
         redir = jr || jump || branch_taken;
         if (jr) begin
`ifdef MISALIGN_TRAP_EN
            tgt = jr_target;
`else
            tgt = (jr_target / 4) * 4;
`endif
         end else if (jump)
            tgt = ((m_pc + 4) & 32'hF000_0000) | (32'(jump_addr) * 4);
         else
            tgt = m_pc + 4 + 32'(int'($signed(branch_imm)) * 4);
         adv = !m_stalled && imem_ready && !stall;
         if (halt_req) begin
            m_phase = 2; m_pend_v = 0;
         end else begin
            if (adv) begin
               applied = redir ? tgt : (m_pend_v ? m_pend : m_pc + 4);
`ifdef MISALIGN_TRAP_EN
               if (applied % 4 != 0) begin
                  m_phase = 2; m_mis = 1; m_pend_v = 0;
               end else begin
                  m_pc = applied; m_pend_v = 0;
               end
`else
               m_pc = applied; m_pend_v = 0;
`endif
            end else if (redir) begin
               m_pend_v = 1; m_pend = tgt;
            end
            m_stalled = stall;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_pc", pc, m_pc);
         check("model_pc_plus4", pc_plus4, m_pc + 32'd4);
         check("model_imem_req", 32'(imem_req), 32'(m_phase == 1));
         check("model_halted", 32'(halted), 32'(m_phase == 2));
         check("model_misaligned", 32'(misaligned), 32'(m_mis));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      stall = 0; imem_ready = 1; branch_taken = 0; jump = 0; jr = 0; halt_req = 0;
   endtask

   task automatic do_jr(input logic [31:0] t);
      jr = 1; jr_target = t; tick(); jr = 0;
   endtask

   initial begin
      idle();
      rst = 1; tick(); tick();
      chk_en = 1'b1;
      check("rst_pc", pc, 32'h0040_0000);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_misaligned", 32'(misaligned), 32'd0);
      rst = 0; tick();
      check("hold_exit_imem_req", 32'(imem_req), 32'd1);
      check("hold_exit_pc", pc, 32'h0040_0000);
      repeat (5) tick();
      check("five_seq_pc", pc, 32'h0040_0014);

      do_jr(32'h100);
      check("jr_pc", pc, 32'h100);
      branch_taken = 1; branch_imm = 16'hFFFE; tick(); branch_taken = 0;
      check("br_back_pc", pc, 32'h0000_00FC);
      do_jr(32'h100);
      branch_taken = 1; branch_imm = 16'h0003; tick(); branch_taken = 0;
      check("br_fwd_pc", pc, 32'h0000_0110);

      do_jr(32'h9000_0000);
      jump = 1; jump_addr = 26'h0000040; tick(); jump = 0;
      check("jump_pc", pc, 32'h9000_0100);
      jump = 1; jr = 1; jr_target = 32'h2000; tick(); jump = 0; jr = 0;
      check("jr_over_jump_pc", pc, 32'h0000_2000);

      imem_ready = 0; branch_taken = 1; branch_imm = 16'h0004; tick(); branch_taken = 0;
      tick(); tick();
      check("not_ready_hold_pc", pc, 32'h0000_2000);
      imem_ready = 1; tick();
      check("pending_applied_pc", pc, 32'h0000_2014);

      stall = 1; tick(); tick();
      check("stall_hold_pc", pc, 32'h0000_2014);
      check("stall_imem_req", 32'(imem_req), 32'd1);
      stall = 0; tick(); tick();
      check("after_stall_pc", pc, 32'h0000_2018);

      do_jr(32'hFFFF_FFFC);
      tick();
      check("wrap_pc", pc, 32'h0000_0000);

      halt_req = 1; branch_taken = 1; tick(); halt_req = 0; branch_taken = 0;
      check("halt_pc", pc, 32'h0000_0000);
      check("halt_flag", 32'(halted), 32'd1);
      repeat (3) tick();
      check("halt_imem_req", 32'(imem_req), 32'd0);
      check("halt_stuck_pc", pc, 32'h0000_0000);
      rst = 1; tick(); rst = 0;
      check("rst_after_halt_pc", pc, RV);
      check("rst_after_halt_flag", 32'(halted), 32'd0);
      tick();

      do_jr(32'h1002);
`ifdef MISALIGN_TRAP_EN
      check("misalign_flag", 32'(misaligned), 32'd1);
      check("misalign_halted", 32'(halted), 32'd1);
      check("misalign_pc_hold", pc, RV);
`else
      check("misalign_forced_pc", pc, 32'h0000_1000);
      check("misalign_flag_tied", 32'(misaligned), 32'd0);
`endif

      rst = 1; tick(); rst = 0;
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 199) == 0);
         stall        = ($urandom_range(0, 3) == 0);
         imem_ready   = ($urandom_range(0, 9) < 7);
         branch_taken = ($urandom_range(0, 9) == 0);
         jump         = ($urandom_range(0, 11) == 0);
         jr           = ($urandom_range(0, 11) == 0);
         halt_req     = ($urandom_range(0, 299) == 0);
         branch_imm   = 16'($urandom);
         jump_addr    = 26'($urandom);
         jr_target    = $urandom;
         if ($urandom_range(0, 7) != 0) jr_target[1:0] = 2'b00;
         if (halted && $urandom_range(0, 19) == 0) rst = 1;
         tick();
      end
      idle(); rst = 0; tick();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
